sync_fifo_ctrl_16x8: RTL



---
 rtl/sync_fifo_ctrl_16x8_pkg.sv | 14 +
 rtl/sync_fifo_ctrl_16x8_if.sv | 22 ++
 rtl/sync_dual_port_sram_16x8.sv | 22 ++
 rtl/sync_fifo_ctrl_16x8_ptr.sv | 20 ++
 rtl/sync_fifo_ctrl_16x8.sv | 132 +++++++++++++
 5 files changed

// File: rtl/sync_fifo_ctrl_16x8_pkg.sv
// rtl/sync_fifo_ctrl_16x8_pkg.sv - shared FIFO widths, depth and mode encoding
package fifo_pkg;

    localparam int FIFO_DW    = 8;
    localparam int FIFO_AW    = 4;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        MID   = 2'b01,
        FULL  = 2'b10
    } mode_t;

endpackage

// File: rtl/sync_fifo_ctrl_16x8_if.sv
// rtl/sync_fifo_ctrl_16x8_if.sv - SRAM port bundle between FIFO controller and dual-port SRAM
interface sram_bus_if #(
    parameter int DW = fifo_pkg::FIFO_DW,
    parameter int AW = fifo_pkg::FIFO_AW
);
    logic          we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] data_w;
    logic          en;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] data_r;

    modport master (
        output we, w_addr, data_w, en, r_addr,
        input  data_r
    );

    modport slave (
        input  we, w_addr, data_w, en, r_addr,
        output data_r
    );
endinterface

// File: rtl/sync_dual_port_sram_16x8.sv
// rtl/sync_dual_port_sram_16x8.sv - 16x8 dual-port SRAM with registered read port
module sync_dual_port_sram_16x8 (
    input logic       clk,
    sram_bus_if.slave bus
);
    import fifo_pkg::*;

    logic [FIFO_DW-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_DW-1:0] r_data_r;

    always_ff @(posedge clk) begin
        if (bus.we) begin
            r_mem[bus.w_addr] <= bus.data_w;
        end
        if (bus.en) begin
            r_data_r <= r_mem[bus.r_addr];
        end
    end

    assign bus.data_r = r_data_r;

endmodule

// File: rtl/sync_fifo_ctrl_16x8_ptr.sv
// rtl/sync_fifo_ctrl_16x8_ptr.sv - wrap-around AW-bit pointer with increment and clear
module fifo_ptr_ctr #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW-1:0] o_ptr
);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            o_ptr <= '0;
        end else if (i_inc) begin
            o_ptr <= o_ptr + AW'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl_16x8.sv
// rtl/sync_fifo_ctrl_16x8.sv - FIFO controller turning a dual-port SRAM into a 16-deep byte FIFO
module sync_fifo_ctrl_16x8
    import fifo_pkg::*;
#(
    parameter int DW     = FIFO_DW,
    parameter int AW     = FIFO_AW,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    sram_bus_if.master    sram
);

    localparam int CW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    mode_t          r_mode;
    mode_t          w_mode_nxt;
    logic [AW:0]    r_count;
    logic [AW:0]    w_count_nxt;
    logic           r_dout_valid;
    logic           r_overflow;
    logic           r_underflow;
    logic           w_push_ok;
    logic           w_pop_ok;
    logic [AW-1:0]  w_wptr;
    logic [AW-1:0]  w_rptr;

    assign full  = (r_mode == FULL);
    assign empty = (r_mode == EMPTY);

    // rst and flush both veto SRAM access so nothing lands in or leaves the RAM that cycle
    assign w_push_ok = push && !full  && !flush && !rst;
    assign w_pop_ok  = pop  && !empty && !flush && !rst;

    fifo_ptr_ctr #(.AW(AW)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_push_ok),
        .o_ptr (w_wptr)
    );

    fifo_ptr_ctr #(.AW(AW)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_pop_ok),
        .o_ptr (w_rptr)
    );

    always_comb begin
        w_mode_nxt  = r_mode;
        w_count_nxt = r_count;
        if (flush) begin
            w_mode_nxt  = EMPTY;
            w_count_nxt = '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
            unique case (r_mode)
                EMPTY: begin
                    if (w_push_ok) w_mode_nxt = MID;
                end
                MID: begin
                    if (w_push_ok && !w_pop_ok && r_count == CW'(DEPTH - 1)) begin
                        w_mode_nxt = FULL;
                    end else if (w_pop_ok && !w_push_ok && r_count == CW'(1)) begin
                        w_mode_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop_ok) w_mode_nxt = MID;
                end
                default: w_mode_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode       <= EMPTY;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_count      <= w_count_nxt;
            r_dout_valid <= w_pop_ok;
            if (flush) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                r_overflow  <= r_overflow  | (push && full);
                r_underflow <= r_underflow | (pop  && empty);
            end
        end
    end

    assign count        = r_count;
    assign almost_full  = (r_count >= CW'(AF_LVL));
    assign almost_empty = (r_count <= CW'(AE_LVL));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign dout_valid   = r_dout_valid;
    assign dout         = sram.data_r;

    assign sram.we     = w_push_ok;
    assign sram.w_addr = w_wptr;
    assign sram.data_w = din;
    assign sram.en     = w_pop_ok;
    assign sram.r_addr = w_rptr;

endmodule
